mux8_bus_arbiter: RTL

- Round-robin arbiter for the shared 32-bit 8:1 result/bus multiplexer in the CPU datapath.
- Accepts up to 8 requesters and grants exactly one at a time.
- Drives the mux 3-bit select directly, plus a one-hot grant to each requester.
- Enforces a bounded hold time so no requester starves the shared bus.

---
 rtl/mux8_bus_arbiter_pkg.sv | 14 +
 rtl/mux8_bus_arbiter_pick.sv | 35 +++
 rtl/mux8_bus_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mux8_bus_arbiter_pkg.sv
// Shared constants for the 8-way round-robin bus arbiter.
package mux8_bus_arbiter_pkg;

  localparam int unsigned NREQ  = 8;
  localparam int unsigned SEL_W = 3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  function automatic logic [NREQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
    return 8'b1 << idx;
  endfunction

endpackage

// File: rtl/mux8_bus_arbiter_pick.sv
// Round-robin picker: rotate masked requests so ptr is bit 0, find the
// lowest set bit, then rotate the index back.
module rr_pick8
  import mux8_bus_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  mask,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [NREQ-1:0]   masked;
  logic [2*NREQ-1:0] dbl;
  logic [2*NREQ-1:0] shifted;
  logic [NREQ-1:0]   rot;
  logic [SEL_W-1:0]  k;

  assign masked  = req & mask;
  assign dbl     = {masked, masked};
  assign shifted = dbl >> ptr;
  assign rot     = shifted[NREQ-1:0];

  // Lowest set bit of the rotated vector wins; scanning downward lets it overwrite.
  always_comb begin
    k = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) k = SEL_W'(i);
    end
  end

  assign found = |rot;
  assign idx   = k + ptr;

endmodule

// File: rtl/mux8_bus_arbiter.sv
// Round-robin arbiter for the shared 8:1 datapath mux with bounded hold time.
module mux8_bus_arbiter
  import mux8_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  output logic [NREQ-1:0]       gnt,
  output logic [SEL_W-1:0]      sel,
  output logic                  busy,
  output logic                  handover,
  output logic [CNT_W-1:0]      hold_cnt
);

  // Last hold count value before a pending contender takes the bus.
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  logic [0:0]       state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             handover_q, handover_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [NREQ-1:0]  pick_mask;
  logic [SEL_W-1:0] pick_ptr;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;
  logic [SEL_W-1:0] owner_next;
  logic             owner_req;
  logic             others_pending;
  logic             preempt;

  assign owner_next     = sel_q + 3'd1;
  assign owner_req      = req[sel_q];
  assign others_pending = |(req & ~onehot8(sel_q));
  assign preempt        = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST) && others_pending;

  // While granted, search starts just past the owner and excludes it.
  always_comb begin
    pick_mask = 8'hFF;
    pick_ptr  = ptr_q;
    if (state_q == ST_GRANT) begin
      pick_mask = ~onehot8(sel_q);
      pick_ptr  = owner_next;
    end
  end

  rr_pick8 u_pick (
    .req   (req),
    .mask  (pick_mask),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Next-state logic for grant, select, pointer and hold counter.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    handover_d = 1'b0;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_IDLE: begin
        gnt_d      = '0;
        hold_cnt_d = '0;
        if (pick_found) begin
          state_d = ST_GRANT;
          gnt_d   = onehot8(pick_idx);
          sel_d   = pick_idx;
        end
      end
      default: begin
        if (!owner_req || preempt) begin
          ptr_d      = owner_next;
          hold_cnt_d = '0;
          if (pick_found) begin
            gnt_d      = onehot8(pick_idx);
            sel_d      = pick_idx;
            handover_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      sel_q      <= '0;
      ptr_q      <= '0;
      handover_q <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      handover_q <= handover_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt      = gnt_q;
  assign sel      = sel_q;
  assign busy     = (state_q == ST_GRANT);
  assign handover = handover_q;
  assign hold_cnt = hold_cnt_q;

endmodule
